// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//
// Two-requester front end for a shared bitwise logic unit (NOT/AND/OR/XOR).
// One operation is in flight at a time: a requester is granted in IDLE, its
// operands are latched, the result is registered in EXEC and presented on the
// shared resp_data register in RESP until the granted requester takes it.
// On equal contention the 1-bit priority pointer decides; it moves to the
// losing requester each time a response is consumed.
//
// Ports
//   clock                        rising-edge clock
//   resetn                       synchronous active-low reset
//   req0_valid / req1_valid      operation pending
//   req0_ready / req1_ready      operation accepted this cycle
//   req0_op / req1_op            00 NOT a, 01 AND, 10 OR, 11 XOR
//   req0_a/b, req1_a/b           operands (b unused for NOT)
//   resp0_valid / resp1_valid    result available for that requester
//   resp0_ready / resp1_ready    requester consumes the result
//   resp_data                    shared result register
//   op_count                     completed responses, saturating
//                                (only with LOGIC_UNIT_ARBITER_STATS_EN)
//
// Build option: define LOGIC_UNIT_ARBITER_STATS_EN to add op_count.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; grant one valid requester
// EXEC  | compute latched op, register result into resp_data
// RESP  | resp*_valid to the granted requester until its resp*_ready

module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             grant_id;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic             any_req;
    logic             sel_id;
    logic             accept;
    logic             resp_hs;

    // Pointer only matters when both are valid; otherwise the lone requester wins.
    assign any_req = req0_valid | req1_valid;
    assign sel_id  = (req0_valid & req1_valid) ? prio : req1_valid;
    // Gated by resetn so no grant can be shown while reset is being sampled.
    assign accept  = resetn & (state == ST_IDLE) & any_req;
    assign resp_hs = (state == ST_RESP) & (grant_id ? resp1_ready : resp0_ready);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (resp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = accept & ~sel_id;
        req1_ready  = accept & sel_id;
        resp0_valid = (state == ST_RESP) & ~grant_id;
        resp1_valid = (state == ST_RESP) & grant_id;
    end

    always_comb begin
        result = '0;
        case (op_q)
            OP_NOT:  result = ~a_q;
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            default: result = a_q ^ b_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            prio      <= 1'b0;
            grant_id  <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                grant_id <= sel_id;
                op_q     <= sel_id ? req1_op : req0_op;
                a_q      <= sel_id ? req1_a  : req0_a;
                b_q      <= sel_id ? req1_b  : req0_b;
            end
            if (state == ST_EXEC) begin
                resp_data <= result;
            end
            if (resp_hs) begin
                prio <= ~grant_id;
            end
        end
    end

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            op_count_q <= 16'h0000;
        end else if (resp_hs && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'h0001;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter. Inputs are driven just after the
// falling edge; outputs are sampled 1 time unit after the falling edge.

module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             resetn;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             resp0_valid, resp1_valid;
    logic             resp0_ready, resp1_ready;
    logic [WIDTH-1:0] resp_data;
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    logic [15:0]      op_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_op     (req0_op),
        .req1_op     (req1_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp0_ready (resp0_ready),
        .resp1_ready (resp1_ready),
        .resp_data   (resp_data)
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
        ,
        .op_count    (op_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({tag, " grant seen"}, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        #1;
        while (!(resp0_valid || resp1_valid) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({tag, " resp seen"}, 32'(n < 20), 32'd1);
    endtask

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    task automatic run_op(input bit who);
        if (who) begin
            req1_valid = 1'b1; req1_op = 2'b11; resp1_ready = 1'b1;
        end else begin
            req0_valid = 1'b1; req0_op = 2'b11; resp0_ready = 1'b1;
        end
        wait_grant("stats");
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp("stats");
        @(negedge clock);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        req0_valid  = 1'b0;  req1_valid  = 1'b0;
        req0_op     = 2'b00; req1_op     = 2'b00;
        req0_a      = '0;    req0_b      = '0;
        req1_a      = '0;    req1_b      = '0;
        resp0_ready = 1'b0;  resp1_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst req0_ready",  32'(req0_ready),  32'd0);
        check("rst req1_ready",  32'(req1_ready),  32'd0);
        check("rst resp0_valid", 32'(resp0_valid), 32'd0);
        check("rst resp1_valid", 32'(resp1_valid), 32'd0);
        check("rst resp_data",   resp_data,        32'h0);

        // NOT on req0; request is already pending while reset is held
        req0_valid = 1'b1; req0_op = 2'b00;
        req0_a = 32'h0000FFFF; req0_b = 32'h12345678;
        resp0_ready = 1'b1;
        #1;
        check("rst no grant", 32'(req0_ready), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("t1 req0_ready", 32'(req0_ready), 32'd1);
        check("t1 req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clock);
        #1;
        check("t1 exec ready",       32'(req0_ready),  32'd0);
        check("t1 exec resp0_valid", 32'(resp0_valid), 32'd0);
        req0_valid = 1'b0;
        req0_a = 32'hDEADBEEF;      // must not disturb the in-flight op
        @(negedge clock);
        #1;
        check("t1 resp0_valid", 32'(resp0_valid), 32'd1);
        check("t1 resp1_valid", 32'(resp1_valid), 32'd0);
        check("t1 resp_data",   resp_data,        32'hFFFF0000);
        @(negedge clock);
        #1;
        check("t1 done resp0_valid", 32'(resp0_valid), 32'd0);
        resp0_ready = 1'b0;
        #1;
        check("idle no ready", 32'(req0_ready | req1_ready), 32'd0);

        // XOR on req1
        req1_valid = 1'b1; req1_op = 2'b11;
        req1_a = 32'hAAAAAAAA; req1_b = 32'hFFFF0000;
        resp1_ready = 1'b1;
        #1;
        check("t2 req1_ready", 32'(req1_ready), 32'd1);
        check("t2 req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clock);
        req1_valid = 1'b0;
        #1;
        check("t2 exec ready", 32'(req1_ready), 32'd0);
        @(negedge clock);
        #1;
        check("t2 resp1_valid", 32'(resp1_valid), 32'd1);
        check("t2 resp0_valid", 32'(resp0_valid), 32'd0);
        check("t2 resp_data",   resp_data,        32'h5555AAAA);
        @(negedge clock);
        #1;
        check("t2 done resp1_valid", 32'(resp1_valid), 32'd0);
        resp1_ready = 1'b0;

        // Both valid continuously after reset: grants alternate 0,1,0,1
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h0000000F; req1_b = 32'h000000F0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic        exp_id;
            logic [31:0] exp_data;
            exp_id   = k[0];
            exp_data = exp_id ? 32'h000000FF : 32'hF000F000;
            wait_grant("t3");
            check($sformatf("t3 op%0d req0_ready", k), 32'(req0_ready), 32'(!exp_id));
            check($sformatf("t3 op%0d req1_ready", k), 32'(req1_ready), 32'(exp_id));
            @(negedge clock);
            wait_resp("t3");
            check($sformatf("t3 op%0d resp0_valid", k), 32'(resp0_valid), 32'(!exp_id));
            check($sformatf("t3 op%0d resp1_valid", k), 32'(resp1_valid), 32'(exp_id));
            check($sformatf("t3 op%0d resp_data", k), resp_data, exp_data);
            @(negedge clock);
        end

        // Back-pressure on resp0 for 5 cycles; resp1_ready high has no effect
        req0_op = 2'b00; req0_a = 32'h0F0F0F0F;
        resp0_ready = 1'b0;
        wait_grant("t4");
        check("t4 req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clock);
        wait_resp("t4");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4 hold%0d resp0_valid", i), 32'(resp0_valid), 32'd1);
            check($sformatf("t4 hold%0d resp_data", i), resp_data, 32'hF0F0F0F0);
            check($sformatf("t4 hold%0d req1_ready", i), 32'(req1_ready), 32'd0);
            check($sformatf("t4 hold%0d resp1_valid", i), 32'(resp1_valid), 32'd0);
            @(negedge clock);
            #1;
        end
        resp0_ready = 1'b1;
        #1;
        check("t4 rise resp0_valid", 32'(resp0_valid), 32'd1);
        @(negedge clock);
        #1;
        check("t4 done resp0_valid", 32'(resp0_valid), 32'd0);
        check("t4 next req1_ready",  32'(req1_ready),  32'd1);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Reset while in RESP discards the response and clears the pointer
        @(negedge clock);
        wait_resp("t5");
        check("t5 resp1_valid", 32'(resp1_valid), 32'd1);
        check("t5 resp_data",   resp_data,        32'h000000FF);
        resetn = 1'b0;
        @(negedge clock);
        #1;
        check("t5 rst req0_ready",  32'(req0_ready),  32'd0);
        check("t5 rst req1_ready",  32'(req1_ready),  32'd0);
        check("t5 rst resp0_valid", 32'(resp0_valid), 32'd0);
        check("t5 rst resp1_valid", 32'(resp1_valid), 32'd0);
        check("t5 rst resp_data",   resp_data,        32'h0);
        resetn = 1'b1;
        resp0_ready = 1'b1;
        #1;
        check("t5 regrant req0_ready", 32'(req0_ready), 32'd1);
        check("t5 regrant req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp("t5");
        check("t5 regrant resp0_valid", 32'(resp0_valid), 32'd1);
        check("t5 regrant resp_data",   resp_data,        32'hF0F0F0F0);
        @(negedge clock);
        resp0_ready = 1'b0;

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("stats reset", 32'(op_count), 32'd0);
        run_op(1'b0);
        run_op(1'b1);
        run_op(1'b0);
        #1;
        check("stats three", 32'(op_count), 32'd3);
        force dut.op_count_q = 16'hFFFE;
        @(negedge clock);
        release dut.op_count_q;
        #1;
        check("stats preload", 32'(op_count), 32'h0000FFFE);
        run_op(1'b1);
        run_op(1'b0);
        run_op(1'b1);
        #1;
        check("stats saturate", 32'(op_count), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
